// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write
// ports (port 1 wins on a shared address), optional same-cycle write->read
// forwarding, and a per-register busy scoreboard for decode-stage stalls.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  output logic [NUM_RD-1:0]        ReadBusy,
  input  logic [ADDR_W-1:0]        WriteReg0,
  input  logic [DATA_W-1:0]        WriteData0,
  input  logic                     RegWrite0,
  input  logic [ADDR_W-1:0]        WriteReg1,
  input  logic [DATA_W-1:0]        WriteData1,
  input  logic                     RegWrite1,
  input  logic [ADDR_W-1:0]        ResvReg,
  input  logic                     ResvEn
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic              we0;
  logic              we1;
  logic              rv;

  // Effective enables: register 0 swallows writes and reservations when hardwired.
  always_comb begin
    we0 = RegWrite0 && !((ZERO_REG != 0) && (WriteReg0 == '0));
    we1 = RegWrite1 && !((ZERO_REG != 0) && (WriteReg1 == '0));
    rv  = ResvEn    && !((ZERO_REG != 0) && (ResvReg   == '0));
  end

  // Scoreboard next state: writes retire a producer, a reservation (newer) wins.
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[WriteReg0] = 1'b0;
    if (we1) busy_nxt[WriteReg1] = 1'b0;
    if (rv)  busy_nxt[ResvReg]   = 1'b1;
  end

  // Array and scoreboard update; port 1 is written last so it wins a shared address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we0) regs[WriteReg0] <= WriteData0;
      if (we1) regs[WriteReg1] <= WriteData1;
      busy <= busy_nxt;
    end
  end

  // Unpack per-port read addresses.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) rd_addr[k] = ReadReg[k*ADDR_W +: ADDR_W];
  end

  // Read ports: array value, overridden by forwarded write data; forced to zero in reset.
  always_comb begin
    ReadData = '0;
    ReadBusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ReadData[k*DATA_W +: DATA_W] = regs[rd_addr[k]];
      ReadBusy[k]                  = busy[rd_addr[k]];
      if ((BYPASS != 0) && we1 && (WriteReg1 == rd_addr[k])) begin
        ReadData[k*DATA_W +: DATA_W] = WriteData1;
        ReadBusy[k]                  = 1'b0;
      end else if ((BYPASS != 0) && we0 && (WriteReg0 == rd_addr[k])) begin
        ReadData[k*DATA_W +: DATA_W] = WriteData0;
        ReadBusy[k]                  = 1'b0;
      end
      if (((ZERO_REG != 0) && (rd_addr[k] == '0)) || reset) begin
        ReadData[k*DATA_W +: DATA_W] = '0;
        ReadBusy[k]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters: 32x32, 3 read ports,
// zero register and bypass enabled). Directed scenarios plus random traffic
// compared against a behavioural model held in plain arrays.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int DEPTH = 32;

  logic            clk;
  logic            reset;
  logic [NR*AW-1:0] read_reg;
  logic [NR*DW-1:0] read_data;
  logic [NR-1:0]    read_busy;
  logic [AW-1:0]    write_reg0, write_reg1, resv_reg;
  logic [DW-1:0]    write_data0, write_data1;
  logic             reg_write0, reg_write1, resv_en;

  int checks;
  int failures;

  logic [DW-1:0] mem_m  [DEPTH];
  logic          busy_m [DEPTH];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .ReadReg    (read_reg),
    .ReadData   (read_data),
    .ReadBusy   (read_busy),
    .WriteReg0  (write_reg0),
    .WriteData0 (write_data0),
    .RegWrite0  (reg_write0),
    .WriteReg1  (write_reg1),
    .WriteData1 (write_data1),
    .RegWrite1  (reg_write1),
    .ResvReg    (resv_reg),
    .ResvEn     (resv_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] port_addr(input int k);
    return read_reg[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] port_data(input int k);
    return read_data[k*DW +: DW];
  endfunction

  // What a reader should see this cycle: r0 is zero, a write this cycle forwards
  // (port 1 preferred), otherwise the stored value.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (reset || a == 0) return '0;
    if (reg_write1 && write_reg1 == a) return write_data1;
    if (reg_write0 && write_reg0 == a) return write_data0;
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (reset || a == 0) return 1'b0;
    if ((reg_write1 && write_reg1 == a) || (reg_write0 && write_reg0 == a)) return 1'b0;
    return busy_m[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    reg_write0 = 0; reg_write1 = 0; resv_en = 0;
    write_reg0 = 0; write_reg1 = 0; resv_reg = 0;
    write_data0 = 0; write_data1 = 0;
  endtask

  task automatic set_all_reads(input logic [AW-1:0] a);
    for (int k = 0; k < NR; k++) read_reg[k*AW +: AW] = a;
  endtask

  // Settle, then compare every read port to the model.
  task automatic step();
    #1;
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd_data_p%0d_a%0d", k, port_addr(k)), port_data(k), exp_data(port_addr(k)));
      chk($sformatf("rd_busy_p%0d_a%0d", k, port_addr(k)), {31'b0, read_busy[k]},
          {31'b0, exp_busy(port_addr(k))});
    end
  endtask

  // Advance one clock and apply the architectural update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (reg_write0 && write_reg0 != 0) begin
        mem_m[write_reg0]  = write_data0;
        busy_m[write_reg0] = 1'b0;
      end
      if (reg_write1 && write_reg1 != 0) begin
        mem_m[write_reg1]  = write_data1;
        busy_m[write_reg1] = 1'b0;
      end
      if (resv_en && resv_reg != 0) busy_m[resv_reg] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    model_clear();
    idle_inputs();
    read_reg = '0;
    reset = 1'b1;
    #20;
    reset = 1'b0;
    @(negedge clk);

    // 1: all addresses read zero / not busy after reset
    for (int a = 0; a < DEPTH; a++) begin
      set_all_reads(AW'(a));
      step();
      tick();
    end

    // 2: write r16, forwarded same cycle, stored next cycle
    set_all_reads(5'd16);
    write_reg0 = 5'd16; write_data0 = 32'hAAAAFFFF; reg_write0 = 1;
    step();
    chk("t2_bypass_r16", port_data(0), 32'hAAAAFFFF);
    tick();
    idle_inputs();
    step();
    chk("t2_stored_r16", port_data(0), 32'hAAAAFFFF);
    tick();

    // 3: same-address dual write -> port 1 wins; r0 write dropped
    write_reg0 = 5'd5; write_data0 = 32'h11111111; reg_write0 = 1;
    write_reg1 = 5'd5; write_data1 = 32'h22222222; reg_write1 = 1;
    set_all_reads(5'd5);
    step();
    tick();
    idle_inputs();
    step();
    chk("t3_port1_wins", port_data(1), 32'h22222222);
    tick();
    write_reg0 = 5'd0; write_data0 = 32'hDEADBEEF; reg_write0 = 1;
    set_all_reads(5'd0);
    step();
    chk("t3_r0_bypass", port_data(2), 32'h0);
    tick();
    idle_inputs();
    step();
    chk("t3_r0_stored", port_data(0), 32'h0);
    tick();

    // 4: reserve r7, then retire it through write port 1
    resv_reg = 5'd7; resv_en = 1;
    set_all_reads(5'd7);
    step();
    chk("t4_resv_same_cycle", {31'b0, read_busy[0]}, 32'h0);
    tick();
    idle_inputs();
    step();
    chk("t4_busy_all_ports", {29'b0, read_busy}, 32'h7);
    write_reg1 = 5'd7; write_data1 = 32'h42; reg_write1 = 1;
    step();
    chk("t4_fwd_busy", {29'b0, read_busy}, 32'h0);
    chk("t4_fwd_data", port_data(1), 32'h42);
    tick();
    idle_inputs();
    step();
    chk("t4_busy_cleared", {29'b0, read_busy}, 32'h0);
    tick();

    // 5: reserve and write same register same edge -> stays busy; r0 never busy
    resv_reg = 5'd9; resv_en = 1;
    write_reg0 = 5'd9; write_data0 = 32'h5; reg_write0 = 1;
    set_all_reads(5'd9);
    tick();
    idle_inputs();
    step();
    chk("t5_data_r9", port_data(0), 32'h5);
    chk("t5_busy_r9", {31'b0, read_busy[0]}, 32'h1);
    tick();
    resv_reg = 5'd0; resv_en = 1;
    tick();
    idle_inputs();
    set_all_reads(5'd0);
    step();
    chk("t5_busy_r0", {29'b0, read_busy}, 32'h0);
    tick();

    // 6: async reset mid-cycle clears outputs before the next edge
    write_reg0 = 5'd3; write_data0 = 32'h33; reg_write0 = 1;
    write_reg1 = 5'd4; write_data1 = 32'h44; reg_write1 = 1;
    tick();
    idle_inputs();
    resv_reg = 5'd4; resv_en = 1;
    tick();
    idle_inputs();
    read_reg = {5'd4, 5'd4, 5'd3};
    step();
    chk("t6_pre_r3", port_data(0), 32'h33);
    chk("t6_pre_r4_busy", {31'b0, read_busy[1]}, 32'h1);
    write_reg0 = 5'd3; write_data0 = 32'h99; reg_write0 = 1;
    #1 reset = 1'b1;
    step();
    chk("t6_rst_data_r3", port_data(0), 32'h0);
    chk("t6_rst_data_r4", port_data(1), 32'h0);
    chk("t6_rst_busy", {29'b0, read_busy}, 32'h0);
    tick();
    reset = 1'b0;
    idle_inputs();
    step();
    chk("t6_after_r3", port_data(0), 32'h0);
    tick();

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 500; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      reg_write0  = $urandom_range(0, 1);
      reg_write1  = $urandom_range(0, 1);
      resv_en     = $urandom_range(0, 1);
      write_reg0  = rand_addr();
      write_reg1  = rand_addr();
      resv_reg    = rand_addr();
      write_data0 = $urandom;
      write_data1 = $urandom;
      for (int k = 0; k < NR; k++) read_reg[k*AW +: AW] = rand_addr();
      step();
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
